// File: rtl/char_wr_seq.sv
// rtl/char_wr_seq.sv - write-side address sequencer for tensor core local buffers
// Streams words into a start..end (inclusive, wrapping) address range, one registered write per word.
module char_wr_seq #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_last;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH:0]   r_words;

    logic w_in_ready;
    logic w_accept;
    logic w_complete;
    logic w_start_ok;

    // The output register may be refilled in the same cycle it drains, so a
    // pending write only blocks new input while the memory is stalling it.
    assign w_in_ready = (r_state == S_RUN) && (!r_wr_en || wr_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_complete = r_wr_en && wr_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_last  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_cur   <= start_addr;
                        r_last  <= end_addr;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_cur == r_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_cur <= r_cur + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_complete) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_cur;
            r_wr_data <= in_data;
        end else if (w_complete) begin
            r_wr_en <= 1'b0;
        end
    end

    // Count is cleared on a fresh start and held through DONE for readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words <= '0;
        end else if (w_start_ok) begin
            r_words <= '0;
        end else if (w_complete) begin
            r_words <= r_words + (ADDR_WIDTH + 1)'(1);
        end
    end

    assign in_ready      = w_in_ready;
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign words_written = r_words;

endmodule
